sevenseg_readback: RTL and testbench

//  Inverse of the sevenseg encoder: monitors the multiplexed common-anode display bus (seg_n, an_n)
//  and recovers the 4-bit code shown on each digit. Sits beside the display driver as a readback

---
 rtl/sevenseg_readback_if.sv | 20 ++
 rtl/sevenseg_readback.sv | 141 ++++++++++++++
 tb/tb_sevenseg_readback.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_readback_if.sv
// Event channel from the seven-segment readback checker: one decoded digit change per transfer.
interface sevenseg_readback_if #(
    parameter int unsigned IDXW = 2
);
    logic            out_valid;
    logic            out_ready;
    logic [IDXW-1:0] out_digit;
    logic [3:0]      out_code;
    logic            out_err;

    modport master (
        output out_valid, out_digit, out_code, out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_digit, out_code, out_err,
        output out_ready
    );
endinterface

// File: rtl/sevenseg_readback.sv
// Watches a multiplexed common-anode seven-segment bus and reports each digit whose
// stable glyph differs from the last one seen, via a single-entry valid/ready buffer.
module sevenseg_readback #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [6:0]  GLYPH_MASK    = 7'b0000000,
    localparam int unsigned IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [NUM_DIGITS-1:0] an_n,
    sevenseg_readback_if.master   out_if,
    output logic                  overflow,
    input  logic                  clr_ovf
);

    localparam int unsigned CNTW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNTW-1:0] STABLE = CNTW'(STABLE_CYCLES);
    localparam logic [6:0] GLYPH4  = 7'b0110011 ^ GLYPH_MASK;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_DIGITS-1:0] s_an_q, s_an_d;
    logic [6:0]            s_seg_q, s_seg_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic [3:0]            shadow_q [NUM_DIGITS];
    logic                  valid_q, valid_d;
    logic [IDXW-1:0]       digit_q, digit_d;
    logic [3:0]            code_q, code_d;
    logic                  ovf_q, ovf_d;

    logic                  an_ok;
    logic                  pins_same;
    logic [IDXW-1:0]       idx;
    logic [3:0]            dec_code;
    logic                  fire;
    logic                  load;

    // Priority order matters: a masked digit-4 glyph may alias a later entry.
    function automatic logic [3:0] decode(input logic [6:0] p);
        if      (p == 7'b1111110) return 4'h0;
        else if (p == 7'b0110000) return 4'h1;
        else if (p == 7'b1101101) return 4'h2;
        else if (p == 7'b1111001) return 4'h3;
        else if (p == GLYPH4)     return 4'h4;
        else if (p == 7'b1011011) return 4'h5;
        else if (p == 7'b1011111) return 4'h6;
        else if (p == 7'b1110000) return 4'h7;
        else if (p == 7'b1111111) return 4'h8;
        else if (p == 7'b1111011) return 4'h9;
        else if (p == 7'b1001111) return 4'hC;
        else if (p == 7'b0000101) return 4'hD;
        else if (p == 7'b0000000) return 4'hE;
        else                      return 4'hF;
    endfunction

    always_comb begin
        an_ok     = $onehot(~an_n);
        pins_same = (an_n == s_an_q) && (seg_n == s_seg_q);
        dec_code  = decode(~s_seg_q);
        idx       = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an_q[i]) idx = i[IDXW-1:0];
        end
    end

    always_comb begin
        s_an_d  = an_n;
        s_seg_d = seg_n;
        cnt_d   = cnt_q;
        state_d = state_q;
        fire    = 1'b0;
        if (!an_ok) begin
            cnt_d   = '0;
            state_d = IDLE;
        end else if (!pins_same) begin
            cnt_d   = '0;
            state_d = SETTLE;
        end else begin
            if (cnt_q != STABLE) cnt_d = cnt_q + 1'b1;
            // One decision per stable period: HELD blocks re-reporting until pins move.
            if (state_q != HELD && cnt_d == STABLE) begin
                state_d = HELD;
                fire    = !seen_q[idx] || (shadow_q[idx] != dec_code);
            end
        end
    end

    always_comb begin
        load    = fire && (!valid_q || out_if.out_ready);
        valid_d = load ? 1'b1 : (out_if.out_ready ? 1'b0 : valid_q);
        digit_d = load ? idx : digit_q;
        code_d  = load ? dec_code : code_q;
        ovf_d   = (fire && !load) ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
        seen_d  = seen_q;
        if (fire) seen_d[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_an_q  <= '1;
            s_seg_q <= '1;
            cnt_q   <= '0;
            seen_q  <= '0;
            valid_q <= 1'b0;
            digit_q <= '0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_an_q  <= s_an_d;
            s_seg_q <= s_seg_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            valid_q <= valid_d;
            digit_q <= digit_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    // Shadow contents are only meaningful once seen_q marks them, so no reset is needed.
    always_ff @(posedge clk) begin
        if (fire) shadow_q[idx] <= dec_code;
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_digit = digit_q;
    assign out_if.out_code  = code_q;
    assign out_if.out_err   = (code_q == 4'hF);
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_sevenseg_readback.sv
// Randomised and directed bench for sevenseg_readback with a queue-based scoreboard.
module tb_sevenseg_readback;

    localparam int         ND   = 4;
    localparam int         ST   = 4;
    localparam logic [6:0] MASK = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       overflow;
    logic       clr_ovf;

    sevenseg_readback_if #(.IDXW(2)) out_if ();

    sevenseg_readback #(
        .NUM_DIGITS   (ND),
        .STABLE_CYCLES(ST),
        .GLYPH_MASK   (MASK)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_n   (seg_n),
        .an_n    (an_n),
        .out_if  (out_if),
        .overflow(overflow),
        .clr_ovf (clr_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int digit;
        int code;
        int err;
        int cycle;
    } ev_t;

    ev_t  q[$];
    ev_t  mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   sb_en  = 1'b0;
    int   shadow [ND];
    bit   seen   [ND];
    logic [10:0] prev;

    // Active-high glyph table (bit6 = a) in priority order, with the code each one denotes.
    logic [6:0] glyph_tbl [13] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                   7'b0110011 ^ MASK, 7'b1011011, 7'b1011111, 7'b1110000,
                                   7'b1111111, 7'b1111011, 7'b1001111, 7'b0000101, 7'b0000000};
    int         code_tbl  [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12, 13, 14};

    function automatic int ref_decode(input logic [6:0] p);
        for (int i = 0; i < 13; i++) begin
            if (p == glyph_tbl[i]) return code_tbl[i];
        end
        return 15;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < ND; i++) begin
            seen[i]   = 1'b0;
            shadow[i] = 0;
        end
        prev = '1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Drive a pattern for n edges; a valid pattern held past the settle window is one observation.
    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        int   d;
        int   code;
        ev_t  e;
        an_n  = an;
        seg_n = seg;
        prev  = {an, seg};
        if (sb_en && n >= ST + 1 && $countones(~an) == 1) begin
            d = 0;
            for (int i = 0; i < ND; i++) if (!an[i]) d = i;
            code = ref_decode(~seg);
            if (!seen[d] || shadow[d] != code) begin
                e.digit = d;
                e.code  = code;
                e.err   = (code == 15) ? 1 : 0;
                e.cycle = cyc + 1 + ST;
                q.push_back(e);
            end
            seen[d]   = 1'b1;
            shadow[d] = code;
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && sb_en && out_if.out_valid && out_if.out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got digit=%0d code=%0h err=%0d cyc=%0d exp no event",
                         out_if.out_digit, out_if.out_code, out_if.out_err, cyc);
            end else begin
                mon_e = q.pop_front();
                if (int'(out_if.out_digit) != mon_e.digit || int'(out_if.out_code) != mon_e.code ||
                    int'(out_if.out_err) != mon_e.err || cyc != mon_e.cycle) begin
                    errors++;
                    $display("FAIL event got digit=%0d code=%0h err=%0d cyc=%0d exp digit=%0d code=%0h err=%0d cyc=%0d",
                             out_if.out_digit, out_if.out_code, out_if.out_err, cyc,
                             mon_e.digit, mon_e.code, mon_e.err, mon_e.cycle);
                end
            end
        end
    end

    initial begin
        logic [3:0] inv [4] = '{4'b0011, 4'b1111, 4'b0000, 4'b1010};
        logic [3:0] an;
        logic [6:0] seg;
        logic [6:0] g;

        an_n = 4'hF;
        seg_n = 7'h7F;
        clr_ovf = 1'b0;
        out_if.out_ready = 1'b1;
        rst_n = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_if.out_valid), 0);
        chk("rst_digit", int'(out_if.out_digit), 0);
        chk("rst_code",  int'(out_if.out_code), 0);
        chk("rst_err",   int'(out_if.out_err), 0);
        chk("rst_ovf",   int'(overflow), 0);
        rst_n = 1'b1;
        sb_en = 1'b1;

        hold(4'b1101, 7'b0000110, 5);
        hold(4'b1111, 7'h7F, 3);
        hold(4'b1110, 7'b1001101, 5);
        hold(4'b1110, 7'b1001100, 5);
        hold(4'b1101, 7'b0000110, 6);
        hold(4'b1110, 7'b1001100, 6);
        hold(4'b0011, 7'h12, 20);
        hold(4'b1111, 7'h00, 20);
        g = ~glyph_tbl[7];
        hold(4'b1011, g, 3);
        hold(4'b1011, g ^ 7'b0000100, 1);
        hold(4'b1011, g, 5);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) < 2) an = inv[$urandom_range(0, 3)];
            else an = ~(4'b0001 << $urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       seg = 7'($urandom);
                1:       seg = ~glyph_tbl[$urandom_range(0, 12)];
                default: seg = ~glyph_tbl[$urandom_range(0, 2)];
            endcase
            if ({an, seg} == prev) seg = seg ^ 7'b0000001;
            hold(an, seg, $urandom_range(1, 8));
        end
        hold(4'b1111, 7'h7F, 8);
        chk("queue_drained", q.size(), 0);

        sb_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        out_if.out_ready = 1'b0;
        hold(4'b1110, ~glyph_tbl[2], 5);
        chk("bp_valid", int'(out_if.out_valid), 1);
        chk("bp_digit", int'(out_if.out_digit), 0);
        chk("bp_code",  int'(out_if.out_code), 2);
        hold(4'b1101, ~glyph_tbl[5], 5);
        chk("bp_hold_valid", int'(out_if.out_valid), 1);
        chk("bp_hold_digit", int'(out_if.out_digit), 0);
        chk("bp_hold_code",  int'(out_if.out_code), 2);
        chk("bp_ovf_set",    int'(overflow), 1);
        an_n = 4'hF;
        seg_n = 7'h7F;
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        chk("bp_ovf_clr", int'(overflow), 0);
        hold(4'b1011, ~glyph_tbl[7], 5);
        chk("bp_ovf_again", int'(overflow), 1);

        an_n = 4'hF;
        seg_n = 7'h7F;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst2_valid", int'(out_if.out_valid), 0);
        chk("rst2_digit", int'(out_if.out_digit), 0);
        chk("rst2_code",  int'(out_if.out_code), 0);
        chk("rst2_err",   int'(out_if.out_err), 0);
        chk("rst2_ovf",   int'(overflow), 0);
        clear_model();
        out_if.out_ready = 1'b1;
        sb_en = 1'b1;
        hold(4'b1110, ~glyph_tbl[2], 6);
        hold(4'b1111, 7'h7F, 8);
        chk("queue_drained_final", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
